// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: opcodes, mux selects,
// trap causes, instruction classes and the FSM state type.
package rv_ctrl_pkg;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [6:0] Funct7M = 7'b0000001;
  localparam logic [4:0] AluAdd  = 5'b00000;

  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmU = 3'b011;
  localparam logic [2:0] ImmJ = 3'b100;

  localparam logic [1:0] WbAlu = 2'b00;
  localparam logic [1:0] WbDm  = 2'b01;
  localparam logic [1:0] WbPc4 = 2'b10;
  localparam logic [1:0] WbMul = 2'b11;

  localparam logic [1:0] PcPlus4 = 2'b00;
  localparam logic [1:0] PcAlu   = 2'b01;
  localparam logic [1:0] PcTrap  = 2'b11;

  localparam logic [1:0] CauseNone      = 2'b00;
  localparam logic [1:0] CauseIllegal   = 2'b01;
  localparam logic [1:0] CauseImTimeout = 2'b10;
  localparam logic [1:0] CauseDmTimeout = 2'b11;

  typedef enum logic [2:0] {
    ClsAlu,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsJump,
    ClsMul
  } instr_class_e;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMulWait,
    StMem,
    StWb,
    StTrap
  } state_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Handshake and datapath-control bundle between the control unit (master)
// and the memories / multiplier / datapath (slave).
interface multicycle_control_unit_if;
  logic [31:0] im_rdata;
  logic        im_valid;
  logic        im_req;
  logic        dm_valid;
  logic        dm_req;
  logic        DMWr;
  logic [2:0]  DMCtrl;
  logic        mul_done;
  logic        mul_start;
  logic        ir_wr;
  logic        pc_wr;
  logic [1:0]  pc_src;
  logic [2:0]  ImmSrc;
  logic        ALUASrc;
  logic        ALUBSrc;
  logic [4:0]  ALUOp;
  logic [1:0]  RUDataWrSrc;
  logic        RUWr;
  logic        BrOp;
  logic        trap;
  logic [1:0]  trap_cause;
  logic        busy;

  modport master (
    input  im_rdata, im_valid, dm_valid, mul_done,
    output im_req, dm_req, DMWr, DMCtrl, mul_start, ir_wr, pc_wr, pc_src, ImmSrc,
           ALUASrc, ALUBSrc, ALUOp, RUDataWrSrc, RUWr, BrOp, trap, trap_cause, busy
  );

  modport slave (
    output im_rdata, im_valid, dm_valid, mul_done,
    input  im_req, dm_req, DMWr, DMCtrl, mul_start, ir_wr, pc_wr, pc_src, ImmSrc,
           ALUASrc, ALUBSrc, ALUOp, RUDataWrSrc, RUWr, BrOp, trap, trap_cause, busy
  );
endinterface

// File: rtl/rv_decoder.sv
// Combinational RV32I(+M) decoder: maps the latched IR to immediate format,
// ALU operand/operation selects, access size, instruction class and legality.
module rv_decoder
  import rv_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [31:0]  ir,
  output logic [2:0]   imm_src,
  output logic         alu_a_src,
  output logic         alu_b_src,
  output logic [4:0]   alu_op,
  output logic [2:0]   dm_ctrl,
  output instr_class_e instr_class,
  output logic         illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_m;
  logic       unused_ir;

  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign funct7    = ir[31:25];
  assign is_m      = (funct7 == Funct7M);
  assign dm_ctrl   = funct3;
  assign unused_ir = ^{ir[24:15], ir[11:7]};

  // Per-opcode control table; anything not listed is illegal
  always_comb begin
    imm_src     = ImmI;
    alu_a_src   = 1'b0;
    alu_b_src   = 1'b1;
    alu_op      = AluAdd;
    instr_class = ClsAlu;
    illegal     = 1'b0;
    case (opcode)
      OpR: begin
        alu_b_src = 1'b0;
        if (is_m) begin
          if (ENABLE_M) begin
            instr_class = ClsMul;
            alu_op      = {1'b1, funct7[5], funct3};
          end else begin
            illegal = 1'b1;
          end
        end else begin
          alu_op = {1'b0, funct7[5], funct3};
        end
      end
      // Only SRAI borrows ir[30]; for the rest it is immediate data
      OpImm:    alu_op = {1'b0, (funct3 == 3'b101) & funct7[5], funct3};
      OpLoad:   instr_class = ClsLoad;
      OpStore: begin
        imm_src     = ImmS;
        instr_class = ClsStore;
      end
      OpBranch: begin
        imm_src     = ImmB;
        alu_a_src   = 1'b1;
        instr_class = ClsBranch;
      end
      OpJal: begin
        imm_src     = ImmJ;
        alu_a_src   = 1'b1;
        instr_class = ClsJump;
      end
      OpJalr:   instr_class = ClsJump;
      // U-format with A=rs1 marks LUI; the datapath zeroes operand A for it
      OpLui:    imm_src = ImmU;
      OpAuipc: begin
        imm_src   = ImmU;
        alu_a_src = 1'b1;
      end
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: fetch, decode, execute, memory and writeback
// sequencing with memory-timeout and illegal-instruction traps.
module multicycle_control_unit
  import rv_ctrl_pkg::*;
#(
  parameter bit          ENABLE_M    = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
  input logic                       clk,
  input logic                       rst_n,
  multicycle_control_unit_if.master bus
);

  localparam logic [TO_W-1:0] TimeoutMax = TO_W'(MEM_TIMEOUT);

  state_t          state_q;
  logic [TO_W-1:0] cnt_q;
  logic [31:0]     ir_q;
  logic [1:0]      cause_q;

  logic [2:0]   imm_src;
  logic         alu_a_src;
  logic         alu_b_src;
  logic [4:0]   alu_op;
  logic [2:0]   dm_ctrl;
  instr_class_e instr_class;
  logic         illegal;
  logic         cnt_hit;

  assign cnt_hit = (cnt_q == TimeoutMax);

  rv_decoder #(
    .ENABLE_M (ENABLE_M)
  ) u_decoder (
    .ir          (ir_q),
    .imm_src     (imm_src),
    .alu_a_src   (alu_a_src),
    .alu_b_src   (alu_b_src),
    .alu_op      (alu_op),
    .dm_ctrl     (dm_ctrl),
    .instr_class (instr_class),
    .illegal     (illegal)
  );

  // State sequencing, wait-cycle counter, IR copy and pending trap cause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      cnt_q   <= '0;
      ir_q    <= '0;
      cause_q <= CauseNone;
    end else begin
      unique case (state_q)
        StFetch: begin
          // A response on the final allowed cycle still wins over the timeout
          if (bus.im_valid) begin
            ir_q    <= bus.im_rdata;
            cnt_q   <= '0;
            state_q <= StDecode;
          end else if (cnt_hit) begin
            cnt_q   <= '0;
            cause_q <= CauseImTimeout;
            state_q <= StTrap;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDecode: begin
          if (illegal) begin
            cause_q <= CauseIllegal;
            state_q <= StTrap;
          end else begin
            state_q <= StExec;
          end
        end
        StExec: begin
          case (instr_class)
            ClsLoad, ClsStore:  state_q <= StMem;
            ClsBranch, ClsJump: state_q <= StFetch;
            ClsMul:             state_q <= StMulWait;
            default:            state_q <= StWb;
          endcase
        end
        StMulWait: begin
          if (bus.mul_done) state_q <= StWb;
        end
        StMem: begin
          if (bus.dm_valid) begin
            cnt_q   <= '0;
            state_q <= (instr_class == ClsLoad) ? StWb : StFetch;
          end else if (cnt_hit) begin
            cnt_q   <= '0;
            cause_q <= CauseDmTimeout;
            state_q <= StTrap;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWb:    state_q <= StFetch;
        StTrap:  state_q <= StFetch;
        default: state_q <= StFetch;
      endcase
    end
  end

  // Control outputs from state and latched IR; held at defaults while in reset
  always_comb begin
    bus.im_req      = 1'b0;
    bus.dm_req      = 1'b0;
    bus.DMWr        = 1'b0;
    bus.DMCtrl      = 3'b000;
    bus.mul_start   = 1'b0;
    bus.ir_wr       = 1'b0;
    bus.pc_wr       = 1'b0;
    bus.pc_src      = PcPlus4;
    bus.ImmSrc      = ImmI;
    bus.ALUASrc     = 1'b0;
    bus.ALUBSrc     = 1'b0;
    bus.ALUOp       = AluAdd;
    bus.RUDataWrSrc = WbAlu;
    bus.RUWr        = 1'b0;
    bus.BrOp        = 1'b0;
    bus.trap        = 1'b0;
    bus.trap_cause  = CauseNone;
    bus.busy        = 1'b0;
    if (rst_n) begin
      bus.busy = (state_q != StFetch);
      // Keep ALU/memory selects stable from execute through writeback
      if (state_q inside {StExec, StMulWait, StMem, StWb}) begin
        bus.ImmSrc  = imm_src;
        bus.ALUASrc = alu_a_src;
        bus.ALUBSrc = alu_b_src;
        bus.ALUOp   = alu_op;
        bus.DMCtrl  = dm_ctrl;
      end
      unique case (state_q)
        StFetch: begin
          bus.im_req = 1'b1;
          bus.ir_wr  = bus.im_valid;
          bus.pc_wr  = bus.im_valid;
        end
        StExec: begin
          case (instr_class)
            ClsBranch: begin
              bus.BrOp   = 1'b1;
              bus.pc_wr  = 1'b1;
              bus.pc_src = PcAlu;
            end
            ClsJump: begin
              bus.pc_wr       = 1'b1;
              bus.pc_src      = PcAlu;
              bus.RUWr        = 1'b1;
              bus.RUDataWrSrc = WbPc4;
            end
            ClsMul:  bus.mul_start = 1'b1;
            default: ;
          endcase
        end
        StMem: begin
          bus.dm_req = 1'b1;
          bus.DMWr   = (instr_class == ClsStore);
        end
        StWb: begin
          bus.RUWr = 1'b1;
          if (instr_class == ClsLoad)     bus.RUDataWrSrc = WbDm;
          else if (instr_class == ClsMul) bus.RUDataWrSrc = WbMul;
          else                            bus.RUDataWrSrc = WbAlu;
        end
        StTrap: begin
          bus.trap       = 1'b1;
          bus.pc_wr      = 1'b1;
          bus.pc_src     = PcTrap;
          bus.trap_cause = cause_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: two instances (M off / M on) share the
// stimulus; a per-instruction model predicts cycle counts and control pulses.
module tb_multicycle_control_unit;

  localparam int TO = 6;
  localparam int K_ILL = 0, K_ALU = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JMP = 5, K_MUL = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b1;
  logic [31:0] rdata_d = '0;
  logic        im_valid_d = 1'b0, dm_valid_d = 1'b0, mul_done_d = 1'b0;

  multicycle_control_unit_if b0 ();
  multicycle_control_unit_if b1 ();

  assign b0.im_rdata = rdata_d;
  assign b1.im_rdata = rdata_d;
  assign b0.im_valid = ~sel & im_valid_d;
  assign b1.im_valid = sel & im_valid_d;
  assign b0.dm_valid = ~sel & dm_valid_d;
  assign b1.dm_valid = sel & dm_valid_d;
  assign b0.mul_done = ~sel & mul_done_d;
  assign b1.mul_done = sel & mul_done_d;

  multicycle_control_unit #(.ENABLE_M(1'b0), .MEM_TIMEOUT(TO)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.master));
  multicycle_control_unit #(.ENABLE_M(1'b1), .MEM_TIMEOUT(TO)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.master));

  wire       o_im_req    = sel ? b1.im_req : b0.im_req;
  wire       o_dm_req    = sel ? b1.dm_req : b0.dm_req;
  wire       o_dm_wr     = sel ? b1.DMWr : b0.DMWr;
  wire [2:0] o_dm_ctrl   = sel ? b1.DMCtrl : b0.DMCtrl;
  wire       o_mul_start = sel ? b1.mul_start : b0.mul_start;
  wire       o_ir_wr     = sel ? b1.ir_wr : b0.ir_wr;
  wire       o_pc_wr     = sel ? b1.pc_wr : b0.pc_wr;
  wire [1:0] o_pc_src    = sel ? b1.pc_src : b0.pc_src;
  wire [2:0] o_imm       = sel ? b1.ImmSrc : b0.ImmSrc;
  wire       o_a_src     = sel ? b1.ALUASrc : b0.ALUASrc;
  wire       o_b_src     = sel ? b1.ALUBSrc : b0.ALUBSrc;
  wire [4:0] o_alu_op    = sel ? b1.ALUOp : b0.ALUOp;
  wire [1:0] o_wb_src    = sel ? b1.RUDataWrSrc : b0.RUDataWrSrc;
  wire       o_ru_wr     = sel ? b1.RUWr : b0.RUWr;
  wire       o_br        = sel ? b1.BrOp : b0.BrOp;
  wire       o_trap      = sel ? b1.trap : b0.trap;
  wire [1:0] o_cause     = sel ? b1.trap_cause : b0.trap_cause;
  wire       o_busy      = sel ? b1.busy : b0.busy;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal_op(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
  endfunction

  function automatic int classify(input logic [31:0] w, input bit m);
    case (w[6:0])
      7'h33:               return (w[31:25] == 7'h01) ? (m ? K_MUL : K_ILL) : K_ALU;
      7'h13, 7'h37, 7'h17: return K_ALU;
      7'h03:               return K_LD;
      7'h23:               return K_ST;
      7'h63:               return K_BR;
      7'h6F, 7'h67:        return K_JMP;
      default:             return K_ILL;
    endcase
  endfunction

  function automatic logic [31:0] gen(input int k);
    logic [31:0] w;
    w = $urandom;
    case (k)
      0: begin w[6:0] = 7'h33; w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
      1: begin
        w[6:0] = 7'h13;
        if (w[13:12] == 2'b01) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      end
      2: w[6:0] = 7'h03;
      3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h63;
      5: w[6:0] = 7'h6F;
      6: w[6:0] = 7'h67;
      7: w[6:0] = 7'h37;
      8: w[6:0] = 7'h17;
      9: begin w[6:0] = 7'h33; w[31:25] = 7'h01; end
      default: while (legal_op(w[6:0])) w[6:0] = 7'($urandom);
    endcase
    return w;
  endfunction

  task automatic do_reset();
    im_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    mul_done_d = 1'b0;
    rst_n = 1'b0;
    #3;
    chk("rst/im_req", 32'(o_im_req), 0);
    chk("rst/busy", 32'(o_busy), 0);
    chk("rst/trap", 32'(o_trap), 0);
    chk("rst/trap_cause", 32'(o_cause), 0);
    chk("rst/alu_op", 32'(o_alu_op), 0);
    chk("rst/enables", 32'({o_pc_wr, o_ru_wr, o_dm_req, o_ir_wr, o_mul_start}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst/first_im_req", 32'(o_im_req), 1);
  endtask

  // Runs one instruction from its first fetch cycle to the next fetch cycle
  task automatic run_txn(input string nm, input logic [31:0] w, input int im_d,
                         input int dm_d, input int mul_d);
    int t = 0, fk = 0, mk = 0, wk = -1, t_fetched = -1;
    bit left = 0, expired = 0;
    int c_irwr = 0, c_ruwr = 0, c_trap = 0, c_mul = 0, c_dmreq = 0, c_dmwr = 0;
    int c_br = 0, c_pcwr = 0, c_idle = 0;
    logic [1:0] l_wbsrc = '0, l_cause = '0, l_pcsrc = '0;
    logic [2:0] l_dmctrl = '0;
    logic [15:0] snap = '0;
    int kind, fetch_cyc, mem_cyc, e_cycles;
    bit fetch_ok, mem_ok;
    int e_ru = 0, e_trap = 0, e_mul = 0, e_dmreq = 0, e_dmwr = 0, e_br = 0, e_pcwr;
    logic [1:0] e_wbsrc = '0, e_cause = '0, e_pcsrc = '0;
    logic [2:0] e_imm = '0;
    logic e_a = 1'b0, e_b = 1'b1;
    logic [4:0] e_alu = '0;
    rdata_d = w;
    forever begin
      if (left && o_im_req) break;
      if (t >= 400) begin expired = 1; break; end
      if (o_im_req) begin im_valid_d = (fk == im_d); fk++; end
      else im_valid_d = 1'($urandom_range(0, 1));
      if (o_dm_req) begin dm_valid_d = (mk == dm_d); mk++; end
      else dm_valid_d = 1'($urandom_range(0, 1));
      if (wk >= 0) begin
        mul_done_d = (wk == mul_d);
        wk = (wk == mul_d) ? -1 : wk + 1;
      end else mul_done_d = 1'($urandom_range(0, 1));
      #1;
      if (o_ir_wr) begin c_irwr++; t_fetched = t; end
      if (o_ru_wr) begin c_ruwr++; l_wbsrc = o_wb_src; end
      if (o_trap) begin c_trap++; l_cause = o_cause; end
      if (o_mul_start) begin c_mul++; wk = 0; end
      if (o_dm_req) begin c_dmreq++; l_dmctrl = o_dm_ctrl; end
      if (o_dm_wr) c_dmwr++;
      if (o_br) c_br++;
      if (o_pc_wr) begin c_pcwr++; l_pcsrc = o_pc_src; end
      if (!o_busy) c_idle++;
      if (t_fetched >= 0 && t == t_fetched + 2)
        snap = {o_imm, o_a_src, o_b_src, o_alu_op, o_dm_ctrl, 2'b00};
      if (!o_im_req) left = 1;
      t++;
      @(negedge clk);
    end
    chk({nm, "/bound"}, 32'(expired), 0);

    kind = classify(w, sel);
    fetch_ok = (im_d <= TO);
    fetch_cyc = fetch_ok ? im_d + 1 : TO + 1;
    mem_ok = (dm_d <= TO);
    mem_cyc = mem_ok ? dm_d + 1 : TO + 1;
    e_pcwr = fetch_ok ? 1 : 0;
    if (!fetch_ok) begin
      e_cycles = fetch_cyc + 1; e_trap = 1; e_cause = 2'b10; e_pcwr = 1; e_pcsrc = 2'b11;
    end else begin
      case (kind)
        K_ILL: begin
          e_cycles = fetch_cyc + 2; e_trap = 1; e_cause = 2'b01; e_pcwr = 2; e_pcsrc = 2'b11;
        end
        K_ALU: begin e_cycles = fetch_cyc + 3; e_ru = 1; e_wbsrc = 2'b00; end
        K_LD, K_ST: begin
          e_dmreq = mem_cyc;
          e_dmwr = (kind == K_ST) ? mem_cyc : 0;
          if (!mem_ok) begin
            e_cycles = fetch_cyc + 2 + mem_cyc + 1; e_trap = 1; e_cause = 2'b11;
            e_pcwr = 2; e_pcsrc = 2'b11;
          end else if (kind == K_LD) begin
            e_cycles = fetch_cyc + 2 + mem_cyc + 1; e_ru = 1; e_wbsrc = 2'b01;
          end else e_cycles = fetch_cyc + 2 + mem_cyc;
        end
        K_BR: begin e_cycles = fetch_cyc + 2; e_br = 1; e_pcwr = 2; e_pcsrc = 2'b01; end
        K_JMP: begin
          e_cycles = fetch_cyc + 2; e_ru = 1; e_wbsrc = 2'b10; e_pcwr = 2; e_pcsrc = 2'b01;
        end
        default: begin e_cycles = fetch_cyc + 2 + mul_d + 1 + 1; e_mul = 1; e_ru = 1;
          e_wbsrc = 2'b11; end
      endcase
    end
    chk({nm, "/cycles"}, t, e_cycles);
    chk({nm, "/ir_wr"}, c_irwr, fetch_ok ? 1 : 0);
    chk({nm, "/busy_low"}, c_idle, fetch_cyc);
    chk({nm, "/ru_wr"}, c_ruwr, e_ru);
    if (e_ru != 0) chk({nm, "/wb_src"}, 32'(l_wbsrc), 32'(e_wbsrc));
    chk({nm, "/trap"}, c_trap, e_trap);
    if (e_trap != 0) chk({nm, "/trap_cause"}, 32'(l_cause), 32'(e_cause));
    chk({nm, "/pc_wr"}, c_pcwr, e_pcwr);
    chk({nm, "/pc_src"}, 32'(l_pcsrc), 32'(e_pcsrc));
    chk({nm, "/mul_start"}, c_mul, e_mul);
    chk({nm, "/dm_req"}, c_dmreq, e_dmreq);
    chk({nm, "/dm_wr"}, c_dmwr, e_dmwr);
    if (e_dmreq != 0) chk({nm, "/dm_ctrl"}, 32'(l_dmctrl), 32'(w[14:12]));
    chk({nm, "/br_op"}, c_br, e_br);
    if (fetch_ok && kind != K_ILL) begin
      case (w[6:0])
        7'h33: begin e_b = 1'b0; e_alu = {w[31:25] == 7'h01, w[30], w[14:12]}; end
        7'h13: e_alu = {1'b0, (w[14:12] == 3'b101) && w[30], w[14:12]};
        7'h23: e_imm = 3'b001;
        7'h63: begin e_imm = 3'b010; e_a = 1'b1; end
        7'h6F: begin e_imm = 3'b100; e_a = 1'b1; end
        7'h37: e_imm = 3'b011;
        7'h17: begin e_imm = 3'b011; e_a = 1'b1; end
        default: ;
      endcase
      chk({nm, "/exec_ctrl"}, 32'(snap), 32'({e_imm, e_a, e_b, e_alu, w[14:12], 2'b00}));
    end
  endtask

  initial begin
    int k, im_d, dm_d;
    sel = 1'b1;
    do_reset();
    run_txn("add", 32'h002081B3, 1, 0, 0);
    run_txn("lw", 32'h0000A103, 0, 2, 0);
    run_txn("sw", 32'h0020A023, 0, 0, 0);
    run_txn("beq", 32'h00208463, 0, 0, 0);
    run_txn("jal", 32'h008000EF, 0, 0, 0);
    run_txn("ill7f", 32'h0000007F, 0, 0, 0);
    run_txn("mul_m1", 32'h022081B3, 0, 0, 4);
    run_txn("im_edge", 32'h002081B3, TO, 0, 0);
    run_txn("im_timeout", 32'h002081B3, TO + 1, 0, 0);
    run_txn("dm_edge", 32'h0000A103, 0, TO, 0);
    run_txn("dm_timeout", 32'h0000A103, 0, TO + 1, 0);

    // Reset pulsed in the middle of a data access
    rdata_d = 32'h0000A103;
    im_valid_d = 1'b1; dm_valid_d = 1'b0; mul_done_d = 1'b0;
    @(negedge clk); im_valid_d = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("midmem/dm_req", 32'(o_dm_req), 1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midmem/dm_req_clr", 32'(o_dm_req), 0);
    chk("midmem/im_req_clr", 32'(o_im_req), 0);
    chk("midmem/busy_clr", 32'(o_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midmem/im_req_back", 32'(o_im_req), 1);
    chk("midmem/dm_req_low", 32'(o_dm_req), 0);
    run_txn("post_rst_add", 32'h40208133, 0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      k = $urandom_range(0, 10);
      im_d = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 1) : $urandom_range(0, 3);
      dm_d = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 1) : $urandom_range(0, 3);
      run_txn($sformatf("rnd_m1_%0d", i), gen(k), im_d, dm_d, $urandom_range(0, 6));
    end

    sel = 1'b0;
    do_reset();
    run_txn("mul_m0", 32'h022081B3, 1, 0, 0);
    run_txn("add_m0", 32'h002081B3, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      k = $urandom_range(0, 10);
      run_txn($sformatf("rnd_m0_%0d", i), gen(k), $urandom_range(0, 2),
              $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
